// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encodings and framing constants for the instruction memory loader
package imem_loader_pkg;

  localparam int LOADER_STATE_WIDTH    = 3;
  localparam int LOADER_BYTES_PER_WORD = 4;
  localparam int LOADER_LEN_BYTES      = 4;

  typedef enum logic [LOADER_STATE_WIDTH-1:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } loader_state_t;

  // States in which the host link may hand us a byte.
  function automatic logic rx_open(input loader_state_t s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - little-endian byte-lane shift-in producing one 32-bit word per 4 bytes
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_LANE = 2'(LOADER_BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic [23:0] r_lanes;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= 2'd0;
      r_lanes <= 24'd0;
    end else if (i_byte_en) begin
      r_cnt <= r_cnt + 2'd1;
      case (r_cnt)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: r_lanes        <= r_lanes;
      endcase
    end
  end

  // The top lane is never stored: the word is presented in the same cycle as its last byte.
  assign o_word_valid = i_byte_en && (r_cnt == LAST_LANE);
  assign o_word       = {i_byte, r_lanes};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory writer; optional trailing XOR checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int MAX_WORDS  = 1024,
  parameter int START_ADDR = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic                 o_mem_wr_ena,
  output logic [BUS_WIDTH-1:0] o_mem_wr_addr,
  output logic [BUS_WIDTH-1:0] o_mem_wr_data,
  output logic                 o_core_hold,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  loader_state_t r_state;
  loader_state_t w_state_next;

  logic                 r_rx_ready;
  logic                 r_wr_ena;
  logic [BUS_WIDTH-1:0] r_wr_addr;
  logic [BUS_WIDTH-1:0] r_wr_data;
  logic                 r_core_hold;
  logic [IDX_W-1:0]     r_w;
  logic [IDX_W-1:0]     r_last_w;

  logic                 w_accept;
  logic                 w_lane_en;
  logic                 w_word_valid;
  logic [31:0]          w_word;
  logic                 w_len_zero;
  logic                 w_len_big;
  logic                 w_last_word;
  logic [BUS_WIDTH-1:0] w_word_addr;

  assign w_accept    = i_rx_valid && r_rx_ready;
  assign w_lane_en   = w_accept && ((r_state == S_LEN) || (r_state == S_DATA));
  assign w_len_zero  = (w_word == 32'd0);
  assign w_len_big   = (w_word > 32'(MAX_WORDS));
  assign w_last_word = (r_w == r_last_w);
  assign w_word_addr = {{(BUS_WIDTH-IDX_W-2){1'b0}}, r_w, 2'b00} + BUS_WIDTH'(START_ADDR);

  imem_loader_word_assembler u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_byte_en    (w_lane_en),
    .i_byte       (i_rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_csum <= 8'd0;
    end else if (w_accept && (r_state == S_DATA)) begin
      r_csum <= r_csum ^ i_rx_data;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_LEN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LEN: begin
        if (w_word_valid) begin
          if (w_len_zero)     w_state_next = S_DONE;
          else if (w_len_big) w_state_next = S_ERR;
          else                w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_valid && w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = S_CSUM;
`else
          w_state_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_state_next = (i_rx_data == r_csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: w_state_next = r_state;
    endcase
  end

  // Ready and hold are registered decodes so the host link sees glitch-free handshakes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_ready  <= 1'b0;
      r_wr_ena    <= 1'b0;
      r_wr_addr   <= BUS_WIDTH'(START_ADDR);
      r_wr_data   <= '0;
      r_core_hold <= 1'b1;
      r_w         <= '0;
      r_last_w    <= '0;
    end else begin
      r_rx_ready  <= rx_open(w_state_next);
      r_core_hold <= (r_state != S_DONE);
      r_wr_ena    <= 1'b0;
      if ((r_state == S_LEN) && w_word_valid) begin
        r_w      <= '0;
        r_last_w <= IDX_W'(w_word - 32'd1);
      end
      if ((r_state == S_DATA) && w_word_valid) begin
        r_wr_ena  <= 1'b1;
        r_wr_data <= BUS_WIDTH'(w_word);
        r_wr_addr <= w_word_addr;
        r_w       <= r_w + 1'b1;
      end
    end
  end

  assign o_rx_ready    = r_rx_ready;
  assign o_mem_wr_ena  = r_wr_ena;
  assign o_mem_wr_addr = r_wr_addr;
  assign o_mem_wr_data = r_wr_data;
  assign o_core_hold   = r_core_hold;
  assign o_done        = (r_state == S_DONE);
  assign o_error       = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

  localparam int          MAXW  = 1024;
  localparam logic [31:0] START = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_ena;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  bit chk_ready = 1'b0;
  logic [63:0] exp_q[$];
  logic [7:0]  case1 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE,
                              8'h78, 8'h56, 8'h34, 8'h12};

  imem_loader #(.BUS_WIDTH(32), .MAX_WORDS(MAXW), .START_ADDR(START)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_rx_ready    (rx_ready),
    .o_mem_wr_ena  (wr_ena),
    .o_mem_wr_addr (wr_addr),
    .o_mem_wr_data (wr_data),
    .o_core_hold   (core_hold),
    .o_done        (done),
    .o_error       (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_ena === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("write_pending", 32'h0, 32'h1);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
      end
    end
    if (chk_ready) check("ready_in_data", 32'(rx_ready), 32'h1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 32'(rx_ready), 32'h1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(rx_ready), 32'h0);
    check({tag, "_wr_ena"}, 32'(wr_ena), 32'h0);
    check({tag, "_wr_addr"}, wr_addr, START);
    check({tag, "_wr_data"}, wr_data, 32'h0);
    check({tag, "_hold"}, 32'(core_hold), 32'h1);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_error"}, 32'(error), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_case1(input int gap_max, input bit watch_ready);
    exp_q.push_back({START, 32'hDEAD_BEEF});
    exp_q.push_back({START + 32'd4, 32'h1234_5678});
    for (int i = 0; i < 12; i++) begin
      send_byte(case1[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
      if (i == 3 && watch_ready) chk_ready = 1'b1;
    end
    chk_ready = 1'b0;
  endtask

  task automatic finish_ok(input string tag);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2A, 0);
`endif
    idle();
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_hold_lag"}, 32'(core_hold), 32'h1);
    check({tag, "_ready_off"}, 32'(rx_ready), 32'h0);
    @(negedge clk);
    check({tag, "_hold_low"}, 32'(core_hold), 32'h0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    check({tag, "_error"}, 32'(error), 32'h0);
  endtask

  initial begin
    int base;

    // reset state
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;

    // case 1: two words back-to-back
    send_case1(0, 1'b0);
    finish_ok("case1");
    check("case1_writes", 32'(wr_count), 32'd2);

    // case 2: zero length
    do_reset();
    base = wr_count;
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    idle();
    check("zero_done", 32'(done), 32'h1);
    check("zero_ready", 32'(rx_ready), 32'h0);
    @(negedge clk);
    check("zero_hold", 32'(core_hold), 32'h0);
    check("zero_no_write", 32'(wr_count - base), 32'd0);

    // case 3: length one past capacity
    do_reset();
    base = wr_count;
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    idle();
    check("big_error", 32'(error), 32'h1);
    check("big_ready", 32'(rx_ready), 32'h0);
    check("big_done", 32'(done), 32'h0);
    repeat (3) @(negedge clk);
    check("big_hold", 32'(core_hold), 32'h1);
    check("big_error_sticky", 32'(error), 32'h1);
    check("big_no_write", 32'(wr_count - base), 32'd0);

    // case 4: random idle gaps
    do_reset();
    send_case1(3, 1'b1);
    finish_ok("gaps");

    // case 5: abort mid-load then replay
    do_reset();
    base = wr_count;
    for (int i = 0; i < 6; i++) send_byte(case1[i], 0);
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    #1;
    check_reset_values("abort_async");
    @(negedge clk);
    check_reset_values("abort_held");
    check("abort_no_write", 32'(wr_count - base), 32'd0);
    rst = 1'b0;
    send_case1(0, 1'b1);
    finish_ok("replay");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // wrong checksum: words land, then error
    do_reset();
    base = wr_count;
    send_case1(0, 1'b0);
    send_byte(8'h2B, 0);
    idle();
    check("csum_bad_error", 32'(error), 32'h1);
    check("csum_bad_done", 32'(done), 32'h0);
    check("csum_bad_hold", 32'(core_hold), 32'h1);
    check("csum_bad_writes", 32'(wr_count - base), 32'd2);
    check("csum_bad_queue", 32'(exp_q.size()), 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
